// File: rtl/ff_share_arbiter.sv
// ff_share_arbiter: N_REQ-way arbiter sharing one registered signed sample stage with valid/ready on both sides.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module ff_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 12,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*W-1:0]    req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic signed [W-1:0]   out_data,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic [15:0]           xfer_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t              r_state, w_state_nxt;
    logic signed [W-1:0] r_data;
    logic [ID_W-1:0]     r_id;
    logic [15:0]         r_cnt;
    logic [ID_W-1:0]     w_ptr;
    logic [ID_W-1:0]     w_gnt;
    logic                w_gnt_vld;
    logic                w_acc;
`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;
    assign w_ptr = r_ptr;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_acc)
            r_ptr <= ID_W'((int'(w_gnt) + 1) % N_REQ);
    end
`endif
    // Scan downward so the nearest valid index at or after w_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(w_ptr) + k) % N_REQ]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = ID_W'((int'(w_ptr) + k) % N_REQ);
            end
        end
    end
    assign out_valid = (r_state == FULL);
    assign w_acc     = rst_n && w_gnt_vld && (!out_valid || out_ready);
    assign req_ready = w_acc ? (N_REQ'(1) << w_gnt) : '0;
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc)
            w_state_nxt = FULL;
        else if (out_ready)
            w_state_nxt = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_data <= req_data[int'(w_gnt) * W +: W];
                r_id   <= w_gnt;
            end
            if (out_valid && out_ready)
                r_cnt <= r_cnt + 16'd1;
        end
    end
    assign out_data = r_data;
    assign out_id   = r_id;
    assign xfer_cnt = r_cnt;
endmodule

// File: tb/tb_ff_share_arbiter.sv
// tb_ff_share_arbiter: directed steps with a scoreboard of accepted samples checked against the output register.
module tb_ff_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [47:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic [15:0] xfer_cnt;

    ff_share_arbiter #(.N_REQ(4), .W(12)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] id; logic [11:0] d;} ent_t;
    ent_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        m_full = 1'b0;
    logic [11:0] m_data = '0;
    logic [1:0]  m_id = '0;
    logic [15:0] m_cnt = '0;
    int          m_ptr = 0;
`ifdef ARB_FIXED_PRIO_EN
    int ids[5] = '{0, 0, 0, 0, 0};
`else
    int ids[5] = '{0, 1, 2, 3, 0};
`endif

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int mgrant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++)
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic setd(input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2, input logic [11:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    // One clock: check combinational ready and current outputs, advance the model, check after the edge.
    task automatic step();
        logic [3:0] er;
        int g;
        #1;
        g = mgrant(req_valid, m_ptr);
        er = (rst_n && g >= 0 && (!m_full || out_ready)) ? 4'(1 << g) : 4'b0;
        chk("req_ready", {28'b0, req_ready}, {28'b0, er});
        chk("out_valid_pre", {31'b0, out_valid}, {31'b0, m_full});
        if (m_full && sb.size() > 0) begin
            chk("sb_data", {20'b0, out_data}, {20'b0, sb[0].d});
            chk("sb_id", {30'b0, out_id}, {30'b0, sb[0].id});
        end
        if (!rst_n) begin
            m_full = 1'b0; m_data = '0; m_id = '0; m_cnt = '0; m_ptr = 0;
            sb.delete();
        end else begin
            if (m_full && out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_cnt++;
                m_full = 1'b0;
            end
            if (er != 4'b0) begin
                m_id = g[1:0];
                m_data = req_data[g*12 +: 12];
                sb.push_back('{m_id, m_data});
                m_full = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                m_ptr = (g + 1) % 4;
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
        chk("out_data", {20'b0, out_data}, {20'b0, m_data});
        chk("out_id", {30'b0, out_id}, {30'b0, m_id});
        chk("xfer_cnt", {16'b0, xfer_cnt}, {16'b0, m_cnt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
        setd(12'h0, 12'h0, 12'h0, 12'h0);
        do_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_cnt", {16'b0, xfer_cnt}, 32'h0);

        // single request from requester 2
        req_valid = 4'b0100; setd(12'h111, 12'h222, 12'hFFB, 12'h333);
        #1 chk("single_ready", {28'b0, req_ready}, 32'h4);
        step();
        chk("single_data", {20'b0, out_data}, 32'hFFB);
        chk("single_id", {30'b0, out_id}, 32'h2);
        req_valid = 4'b0000;
        step();
        chk("single_cnt", {16'b0, xfer_cnt}, 32'h1);
        chk("drain_valid", {31'b0, out_valid}, 32'h0);
        chk("drain_hold", {20'b0, out_data}, 32'hFFB);

        // rotation with all requesters valid
        do_reset();
        req_valid = 4'b1111; setd(12'h064, 12'hF9C, 12'h7FF, 12'h800);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rot_id", {30'b0, out_id}, ids[i]);
        end
        chk("rot_cnt", {16'b0, xfer_cnt}, 32'h4);
        step();

        // backpressure with the register held full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
`ifdef ARB_FIXED_PRIO_EN
        chk("bp_id", {30'b0, out_id}, 32'h0);
`else
        chk("bp_id", {30'b0, out_id}, 32'h1);
`endif
        out_ready = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        #1 chk("bp_release", {28'b0, req_ready}, 32'h1);
`else
        #1 chk("bp_release", {28'b0, req_ready}, 32'h4);
`endif
        step();

        // drain to empty
        req_valid = 4'b0000;
        step();
        chk("drain2_valid", {31'b0, out_valid}, 32'h0);
        step();

        // mid-operation reset
        req_valid = 4'b0001; setd(12'h123, 12'h456, 12'h789, 12'hABC);
        step();
        chk("pre_rst_data", {20'b0, out_data}, 32'h123);
        out_ready = 1'b0;
        rst_n = 1'b0; req_valid = 4'b1111;
        #1 chk("rst_ready", {28'b0, req_ready}, 32'h0);
        step();
        chk("mid_rst_data", {20'b0, out_data}, 32'h0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("post_rst_grant", {28'b0, req_ready}, 32'h1);
        step();

        // two sparse requesters
        req_valid = 4'b1010; setd(12'h001, 12'h0A1, 12'h002, 12'h0A3);
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef ARB_FIXED_PRIO_EN
            chk("fixed_id", {30'b0, out_id}, 32'h1);
`endif
        end

        // counter wrap: 65536 transfers from reset
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) step();
        chk("wrap_cnt", {16'b0, xfer_cnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ff_share_arbiter.md
# ff_share_arbiter

Round-robin arbiter that shares one 12-bit signed pipeline register stage among `N_REQ` requesters in the DNA RTL datapath. Each requester offers a signed sample through a valid/ready handshake. The block grants one requester per cycle and captures the granted sample into a single output register. It presents that sample downstream with the winner's ID under a second valid/ready handshake, with one-cycle latency and full throughput.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 12, sample width, signed
- `ID_W`, `$clog2(N_REQ)`, requester ID width (derived, not overridden)
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester sample valid
- `req_data`  in  N_REQ*W  packed samples; requester i occupies bits [i*W +: W], signed
- `req_ready`  out  N_REQ  one-hot (or zero) acceptance; requester i is accepted when `req_valid[i] && req_ready[i]`
- `out_valid`  out  1  output register holds a sample
- `out_data`  out  W  registered signed sample
- `out_id`  out  ID_W  index of the requester that supplied `out_data`
- `out_ready`  in  1  downstream accepts
- `xfer_cnt`  out  16  completed downstream transfers, wraps modulo 2^16

## Operation
- Two-state FSM on the output register: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- Grant (combinational):
  - Among asserted `req_valid` bits, pick the first index at or after `rr_ptr`, searching upward with wrap past N_REQ-1 to 0.
  - No valid request means no grant.
- Acceptance: `req_ready[g]` = grant present && (EMPTY || `out_ready`). All other `req_ready` bits are 0.
- Accept event (`req_valid[g] && req_ready[g]`):
  - Next edge: `out_data` <= `req_data[g]` bit-exact (no extension or truncation), `out_id` <= g, state -> FULL.
  - `rr_ptr` <= (g+1) mod N_REQ.
- Drain without accept (FULL && `out_ready` && no accept): state -> EMPTY. `out_data` and `out_id` hold their last values.
- Simultaneous drain and accept in FULL: stays FULL, new sample replaces old in the same edge. No bubble.
- FULL && !`out_ready`:
  - All `req_ready` = 0.
  - `out_data` and `out_id` held stable.
  - `rr_ptr` held.
- `xfer_cnt` increments on each `out_valid && out_ready` and wraps from 0xFFFF to 0x0000.
- `req_valid` deasserting without acceptance is legal. The requester is simply not granted.
- `req_ready` never depends on `req_valid` of the same requester being low. It is a function of the arbitration result only.

## Timing
- Reset (rst_n=0 at a posedge) forces:
  - `out_valid`=0, `out_data`=0, `out_id`=0, `xfer_cnt`=0, `rr_ptr`=0, state EMPTY.
  - `req_ready` is forced to all-zero while `rst_n`=0.
- Reset mid-operation discards any held sample. No downstream transfer is counted for it.
- Latency: accept at edge k -> `out_valid`=1 with that sample after edge k, visible in cycle k+1.
- Throughput: one sample per cycle while `out_ready`=1.
- Fairness: with all requesters continuously valid and `out_ready`=1, grants rotate 0,1,..,N_REQ-1,0. No requester waits more than N_REQ-1 accepts.
- `out_data` and `out_id` are register outputs. The only combinational paths are `req_valid`/`out_ready` -> `req_ready`.

## Configuration
- `ARB_FIXED_PRIO_EN` defined:
  - Grant is fixed priority; the lowest asserted index wins.
  - `rr_ptr` is removed (reads as constant 0).
  - All other behaviour is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- Reset then single request: `req_valid`=4'b0100, `req_data[2]`=-5 (12'hFFB), `out_ready`=1.
  - `req_ready`=4'b0100.
  - Next cycle: `out_valid`=1, `out_data`=12'hFFB, `out_id`=2, `xfer_cnt` becomes 1 one cycle later.
- All four valid continuously (data 100, -100, 2047, -2048), `out_ready`=1:
  - `out_id` sequence 0,1,2,3,0.
  - `out_data` 12'h064, 12'hF9C, 12'h7FF, 12'h800.
  - 5 samples in 5 cycles.
- Backpressure:
  - FULL with `out_id`=1, `out_ready`=0 for 3 cycles while `req_valid`=4'b1111: `req_ready`=0, outputs stable, `xfer_cnt` unchanged.
  - `out_ready`=1: requester 2 is accepted the same cycle.
- Drain to empty: single transfer then `req_valid`=0, `out_ready`=1.
  - `out_valid` drops the cycle after the handshake.
  - `out_data` retains its last value.
- Mid-operation reset: FULL with `out_data`=12'h123, `rst_n`=0 for one edge.
  - All outputs 0, `req_ready`=0 during reset.
  - First grant after reset goes to requester 0 when `req_valid`=4'b1111.
- With `ARB_FIXED_PRIO_EN`, `req_valid`=4'b1010 held, `out_ready`=1: `out_id`=1 on every transfer. Requester 3 is never granted.
- Counter wrap: 65536 transfers -> `xfer_cnt` returns to 0.
